pong_overlay: RTL

Pixel-stream consumer of the Pong game state. Snapshots ball position, scores and win flags once per frame on `sync`, then composites the ball, score digits, goal markers and a blinking win tint onto the incoming camera pixel stream. Sits between the camera/paddle-detection video path and the VGA output, downstream of `game_state`. Fixed two-cycle latency and no backpressure.

---
 rtl/pong_overlay.sv | 117 +++++++++++
 1 files changed

// File: rtl/pong_overlay.sv
// pong_overlay: per-frame snapshot of game state composited as ball, score digits,
// goal markers and blinking win tint onto the camera pixel stream (2-cycle latency).
module pong_overlay (
   input  logic        clk,
   input  logic        reset,
   input  logic        sync,
   input  logic        in_valid,
   input  logic [12:0] in_col,
   input  logic [12:0] in_row,
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   input  logic [12:0] ball_col,
   input  logic [12:0] ball_row,
   input  logic [9:0]  p1_score,
   input  logic [9:0]  p2_score,
   input  logic        p1w,
   input  logic        p2w,
   output logic        out_valid,
   output logic [7:0]  out_r,
   output logic [7:0]  out_g,
   output logic [7:0]  out_b
);
   logic [12:0] s_col, s_row;
   logic [3:0]  s_p1, s_p2;
   logic        s_p1w, s_p2w;
   logic [4:0]  blink;
   logic               v1, gl1, gr1, dh1;
   logic [23:0]        rgb1;
   logic signed [13:0] dx1, dy1;
   logic [3:0]         lc1, dig1;
   logic [4:0]         lr1;
   logic [1:0]         t1;
   logic cell_row, h1, h2, goal_row;
   assign cell_row = in_row >= 13'd8 && in_row <= 13'd31;
   assign h1       = cell_row && in_col >= 13'd288 && in_col <= 13'd303;
   assign h2       = cell_row && in_col >= 13'd336 && in_col <= 13'd351;
   assign goal_row = in_row >= 13'd120 && in_row <= 13'd359;
   logic signed [27:0] ex, ey;
   logic [27:0] d2;
   logic        ball_hit, seg_hit;
   logic [6:0]  lit, segs;
   logic [7:0]  hr, hg, hb;
   logic [23:0] pix;
   assign ex       = {{14{dx1[13]}}, dx1};
   assign ey       = {{14{dy1[13]}}, dy1};
   assign d2       = $unsigned(ex * ex) + $unsigned(ey * ey);
   assign ball_hit = d2 <= 28'd64;
   // segment order {a,b,c,d,e,f,g}
   always_comb begin
      lit = 7'b0000000;
      case (dig1)
         4'd0: lit = 7'b1111110;
         4'd1: lit = 7'b0110000;
         4'd2: lit = 7'b1101101;
         4'd3: lit = 7'b1111001;
         4'd4: lit = 7'b0110011;
         4'd5: lit = 7'b1011011;
         4'd6: lit = 7'b1011111;
         4'd7: lit = 7'b1110000;
         4'd8: lit = 7'b1111111;
         4'd9: lit = 7'b1111011;
         default: lit = 7'b0000000;
      endcase
   end
   assign segs = {lr1 <= 5'd2,
                  lc1 >= 4'd13 && lr1 <= 5'd11,
                  lc1 >= 4'd13 && lr1 >= 5'd12,
                  lr1 >= 5'd21 && lr1 <= 5'd23,
                  lc1 <= 4'd2 && lr1 >= 5'd12,
                  lc1 <= 4'd2 && lr1 <= 5'd11,
                  lr1 >= 5'd10 && lr1 <= 5'd12};
   assign seg_hit = dh1 && |(segs & lit);
   assign hr = {1'b0, rgb1[23:17]};
   assign hg = {1'b0, rgb1[15:9]};
   assign hb = {1'b0, rgb1[7:1]};
   assign pix = ball_hit ? 24'hFFFFFF :
                seg_hit  ? 24'hFFFF00 :
                gl1      ? 24'h0000FF :
                gr1      ? 24'hFF0000 :
                t1[1]    ? {8'h80 | hr, hg, hb} :
                t1[0]    ? {hr, hg, 8'h80 | hb} : rgb1;
   // stage 1 carries every snapshot-derived value so a sync-cycle pixel keeps the old frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_col <= '0; s_row <= '0; s_p1 <= '0; s_p2 <= '0;
         s_p1w <= 1'b0; s_p2w <= 1'b0; blink <= '0;
         v1 <= 1'b0; rgb1 <= '0; dx1 <= '0; dy1 <= '0;
         gl1 <= 1'b0; gr1 <= 1'b0; dh1 <= 1'b0;
         lc1 <= '0; lr1 <= '0; dig1 <= '0; t1 <= '0;
         out_valid <= 1'b0; out_r <= '0; out_g <= '0; out_b <= '0;
      end else begin
         if (sync) begin
            s_col <= ball_col;
            s_row <= ball_row;
            s_p1  <= p1_score >= 10'd9 ? 4'd9 : p1_score[3:0];
            s_p2  <= p2_score >= 10'd9 ? 4'd9 : p2_score[3:0];
            s_p1w <= p1w;
            s_p2w <= p2w;
            blink <= blink + 5'd1;
         end
         v1   <= in_valid;
         rgb1 <= {in_r, in_g, in_b};
         dx1  <= $signed({1'b0, in_col}) - $signed({1'b0, s_col});
         dy1  <= $signed({1'b0, in_row}) - $signed({1'b0, s_row});
         gl1  <= goal_row && in_col <= 13'd3;
         gr1  <= goal_row && in_col >= 13'd612 && in_col <= 13'd615;
         dh1  <= h1 | h2;
         lc1  <= h1 ? 4'(in_col - 13'd288) : 4'(in_col - 13'd336);
         lr1  <= 5'(in_row - 13'd8);
         dig1 <= h1 ? s_p1 : s_p2;
         t1   <= {blink[4] & s_p1w, blink[4] & s_p2w & ~s_p1w};
         out_valid <= v1;
         {out_r, out_g, out_b} <= pix;
      end
   end
endmodule
